// File: rtl/proc_pkg.sv
// Shared constants for the multicycle core: opcodes, ALU funcs, field positions, FSM states.
package proc_pkg;

  localparam int INSTR_W = 32;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int FN_MSB  = 26;
  localparam int FN_LSB  = 23;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 19;
  localparam int RS2_MSB = 18;
  localparam int RS2_LSB = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 14;
  localparam int IMM_LSB = 0;

  localparam logic [4:0] OP_AR   = 5'b00000;
  localparam logic [4:0] OP_ARI  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_BZ   = 5'b00100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;
  localparam logic [3:0] FN_SLL = 4'd6;
  localparam logic [3:0] FN_SRL = 4'd7;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/proc_regfile.sv
// Register file: two async read ports, one sync write port, R0 hardwired to zero.
module proc_regfile
  import proc_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/proc_multicycle.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one memory port with ready handshake.
module proc_multicycle
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic              err
);

  localparam int AW  = $clog2(NREGS);
  localparam int SHW = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d, mdr_q, mdr_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic                err_q, err_d;

  logic [4:0]          op;
  logic [3:0]          fn, rs1, rs2, rd;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_ill;
  logic [DATA_W-1:0]   rf_rdata1, rf_rdata2, rf_wdata;
  logic [AW-1:0]       rf_waddr;
  logic                rf_we;

  assign op      = ir_q[OP_MSB:OP_LSB];
  assign fn      = ir_q[FN_MSB:FN_LSB];
  assign rs1     = ir_q[RS1_MSB:RS1_LSB];
  assign rs2     = ir_q[RS2_MSB:RS2_LSB];
  assign rd      = ir_q[RD_MSB:RD_LSB];
  assign imm_ext = {{(DATA_W-15){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};

  // AR writes rd, ARI/LD write the rd_i field that shares bits with rs2
  assign rf_we    = (state_q == WB);
  assign rf_waddr = (op == OP_AR) ? rd[AW-1:0] : rs2[AW-1:0];
  assign rf_wdata = (op == OP_LD) ? mdr_q : res_q;

  proc_regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_rf (
    .clk    (CLK),
    .rst_n  (RESET),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs1[AW-1:0]),
    .raddr2 (rs2[AW-1:0]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_comb begin
    alu_y   = '0;
    alu_ill = 1'b0;
    case (fn)
      FN_ADD:  alu_y = a_q + b_q;
      FN_SUB:  alu_y = a_q - b_q;
      FN_AND:  alu_y = a_q & b_q;
      FN_OR:   alu_y = a_q | b_q;
      FN_XOR:  alu_y = a_q ^ b_q;
      FN_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      FN_SLL:  alu_y = a_q << b_q[SHW-1:0];
      FN_SRL:  alu_y = a_q >> b_q[SHW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= FETCH;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mdr_q   <= '0;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      mdr_q   <= mdr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    mdr_d   = mdr_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      FETCH: if (mem_ready) begin
        ir_d    = INSTR_W'(mem_rdata);
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rf_rdata1;
        b_d     = rf_rdata2;
        state_d = EXEC;
      end
      EXEC: begin
        pc_d = pc_q + DATA_W'(1);
        case (op)
          OP_AR: begin
            if (alu_ill) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              res_d   = alu_y;
              state_d = WB;
            end
          end
          OP_ARI: begin
            res_d   = a_q + imm_ext;
            state_d = WB;
          end
          OP_LD, OP_ST: begin
            res_d   = a_q + imm_ext;
            state_d = MEM;
          end
          OP_BZ: begin
            if (a_q == '0) pc_d = pc_q + DATA_W'(1) + imm_ext;
            state_d = FETCH;
          end
          OP_HALT: state_d = HALT;
          default: begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        endcase
      end
      MEM: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = (op == OP_LD) ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // RESET gating drops any pending access in the same cycle reset is applied
  always_comb begin
    mem_req   = RESET && ((state_q == FETCH) || (state_q == MEM));
    mem_we    = RESET && (state_q == MEM) && (op == OP_ST);
    mem_addr  = (state_q == MEM) ? res_q : pc_q;
    mem_wdata = b_q;
    retire    = RESET && ((state_q == WB) ||
                          ((state_q == MEM) && (op == OP_ST) && mem_ready) ||
                          ((state_q == EXEC) && (op == OP_BZ)));
    halted    = (state_q == HALT);
    err       = err_q;
    pc        = pc_q;
  end

endmodule

// File: tb/tb_proc_multicycle.sv
// Directed bench: memory model with data-region wait states, store scoreboard, cycle checks.
module tb_proc_multicycle;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic          retire, halted, err;

  logic [DW-1:0] rom  [0:63];
  logic [DW-1:0] dmem [0:255];
  int            waits = 0;
  int            wcnt  = 0;
  int            checks = 0;
  int            errors = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  st_t exp_q[$];

  always #5 CLK = ~CLK;

  proc_multicycle #(.DATA_W(DW), .NREGS(16), .RESET_PC('0)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted),
    .err       (err)
  );

  // Addresses below 64 are program space (zero-wait); above that data space with wait states
  always_comb begin
    mem_ready = mem_req && ((mem_addr < 64) || (wcnt >= waits));
    mem_rdata = (mem_addr < 64) ? rom[mem_addr[5:0]] : dmem[mem_addr[7:0]];
  end

  always @(posedge CLK) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (mem_req && mem_we && mem_ready) dmem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(negedge CLK) begin
    if (RESET && mem_req && mem_we && mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected addr=%0d data=%h", mem_addr, mem_wdata);
      end else begin
        st_t e;
        e = exp_q.pop_front();
        if (e.addr !== mem_addr || e.data !== mem_wdata) begin
          errors++;
          $display("FAIL store got addr=%0d data=%h exp addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] enc_ar(input int fn, input int s1, input int s2, input int d);
    return {5'b00000, 4'(fn), 4'(s1), 4'(s2), 4'(d), 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input int s1, input int r2, input int imm);
    return {op, 4'b0, 4'(s1), 4'(r2), 15'(imm)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = {5'b11111, 27'b0};
  endtask

  // Hold reset for n edges, release just after an edge; next negedge samples cycle 1
  task automatic do_reset(input int n);
    @(posedge CLK); #1 RESET = 1'b0;
    repeat (n) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic wait_halt(input string nm, input int lim);
    int t = 0;
    while (!halted && t < lim) begin @(negedge CLK); t++; end
    chk(nm, 32'(halted), 32'd1);
  endtask

  task automatic no_req(input string nm, input int n);
    int seen = 0;
    repeat (n) begin @(negedge CLK); if (mem_req) seen++; end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    int rc, n, bad, dcyc, t;

    // Arithmetic, AR ops, R0 write, branches, stores of every result
    clear_rom();
    rom[0]  = enc_i(5'b00001, 0, 1, 5);
    rom[1]  = enc_i(5'b00001, 0, 2, -3);
    rom[2]  = enc_ar(1, 1, 2, 3);
    rom[3]  = enc_ar(5, 2, 1, 4);
    rom[4]  = enc_ar(7, 2, 1, 5);
    rom[5]  = enc_i(5'b00001, 0, 0, 7);
    rom[6]  = enc_i(5'b00100, 1, 0, 1);
    rom[7]  = enc_i(5'b00011, 0, 1, 200);
    rom[8]  = enc_i(5'b00011, 0, 2, 201);
    rom[9]  = enc_i(5'b00011, 0, 3, 202);
    rom[10] = enc_i(5'b00011, 0, 4, 203);
    rom[11] = enc_i(5'b00011, 0, 5, 204);
    rom[12] = enc_i(5'b00011, 0, 0, 205);
    rom[13] = enc_i(5'b00100, 0, 0, 1);
    rom[14] = enc_i(5'b00011, 0, 1, 206);
    rom[15] = enc_ar(0, 1, 2, 7);
    rom[16] = enc_i(5'b00011, 0, 7, 206);
    push_st(200, 32'd5);
    push_st(201, 32'hFFFF_FFFD);
    push_st(202, 32'd8);
    push_st(203, 32'd1);
    push_st(204, 32'h07FF_FFFF);
    push_st(205, 32'd0);
    push_st(206, 32'd2);
    waits = 0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_retire",  32'(retire),  32'd0);
    chk("rst_halted",  32'(halted),  32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_pc",      pc,           32'd0);
    do_reset(1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) chk("first_fetch", {31'b0, mem_req} | (mem_addr << 1), 32'd1);
      chk($sformatf("ari_retire_c%0d", k), 32'(retire), 32'((k == 4) || (k == 8)));
      if (k == 8) chk("ari_pc", pc, 32'd2);
    end
    wait_halt("p1_halt", 500);
    chk("p1_err", 32'(err), 32'd0);
    chk("p1_sb_empty", 32'(exp_q.size()), 32'd0);
    no_req("p1_no_req_halt", 5);

    // Store then load through a 3-cycle-stalled data port
    clear_rom();
    rom[0] = enc_i(5'b00001, 0, 1, 5);
    rom[1] = enc_i(5'b00011, 0, 1, 100);
    rom[2] = enc_i(5'b00010, 0, 6, 100);
    rom[3] = enc_i(5'b00011, 0, 6, 101);
    push_st(100, 32'd5);
    push_st(101, 32'd5);
    waits = 3;
    do_reset(2);
    rc = 0; t = 0;
    while (rc < 2 && t < 200) begin @(negedge CLK); t++; if (retire) rc++; end
    chk("p2_two_retires", 32'(rc), 32'd2);
    n = 0; bad = 0; dcyc = 0;
    do begin
      @(negedge CLK); n++;
      if (mem_req && mem_addr != 2) begin
        dcyc++;
        if (mem_addr != 100 || mem_we) bad++;
      end
    end while (!retire && n < 50);
    chk("ld_cycles", 32'(n), 32'd8);
    chk("ld_addr_stable", 32'(bad), 32'd0);
    chk("ld_mem_cycles", 32'(dcyc), 32'd4);
    wait_halt("p2_halt", 500);
    chk("p2_sb_empty", 32'(exp_q.size()), 32'd0);

    // BZ on R0 with imm=-1 spins in place, retiring every third cycle
    clear_rom();
    rom[0] = enc_i(5'b00100, 0, 0, -1);
    waits = 0;
    do_reset(1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      chk($sformatf("bz_retire_c%0d", k), 32'(retire), 32'((k % 3) == 0));
    end
    chk("bz_pc", pc, 32'd0);
    chk("bz_halted", 32'(halted), 32'd0);

    // R0 write discarded, then illegal opcode halts with err
    clear_rom();
    rom[0] = enc_i(5'b00001, 0, 0, 7);
    rom[1] = enc_i(5'b00011, 0, 0, 110);
    rom[2] = {5'b01010, 27'b0};
    push_st(110, 32'd0);
    do_reset(1);
    rc = 0; t = 0;
    while (rc < 2 && t < 200) begin @(negedge CLK); t++; if (retire) rc++; end
    n = 0;
    do begin @(negedge CLK); n++; end while (!halted && n < 50);
    chk("ill_halt_cycles", 32'(n), 32'd4);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_halted", 32'(halted), 32'd1);
    no_req("ill_no_req", 10);
    chk("ill_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during a stalled LD: access dropped, R6 stays cleared, fetch restarts at 0
    clear_rom();
    rom[0] = enc_i(5'b00010, 0, 6, 100);
    waits = 3;
    do_reset(1);
    t = 0;
    do begin @(negedge CLK); t++; end while (!(mem_req && mem_addr == 100 && !mem_ready) && t < 100);
    chk("mid_stall_seen", 32'(mem_req && mem_addr == 100 && !mem_ready), 32'd1);
    RESET = 1'b0;
    rom[0] = enc_i(5'b00011, 0, 6, 120);
    rom[1] = {5'b11111, 27'b0};
    push_st(120, 32'd0);
    @(negedge CLK);
    chk("mid_req_drop", 32'(mem_req), 32'd0);
    @(posedge CLK); #1 RESET = 1'b1;
    @(negedge CLK);
    chk("mid_refetch_req", 32'(mem_req), 32'd1);
    chk("mid_refetch_addr", mem_addr, 32'd0);
    wait_halt("mid_halt", 500);
    chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_multicycle.md
# proc_multicycle

Parametrised multicycle processor core, the successor to the single-cycle AR-only datapath. It executes register ALU, immediate ALU, load, store, branch-if-zero and halt instructions. Each instruction runs through a fetch/decode/execute/memory/writeback FSM over one shared memory port with a ready handshake. It sits between the instruction/data memory model and the bench, exposing PC, retire and halt status.

## Interface
- DATA_W, 32: datapath and register width (≥16).
- NREGS, 16: register count, power of 2, ≤16; register fields are 4 bits, upper index bits ignored when NREGS<16.
- RESET_PC, 0: PC value loaded on reset (word address).
- CLK  in  1  single clock, all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr  out  DATA_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete this cycle; may be combinational from mem_req.
- pc  out  DATA_W  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core stopped.
- err  out  1  sticky, set on an illegal opcode or func.

## Operation
- Instruction fields: [31:27] opcode, [26:23] func, [22:19] rs1, [18:15] rs2/rd_i, [14:11] rd, [14:0] imm15, sign-extended to DATA_W.
- AR (00000): rd = rs1 op rs2. Func 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL. Shift amount is rs2[$clog2(DATA_W)-1:0]. Func 8–15 illegal.
- ARI (00001): rd_i = rs1 + imm.
- LD (00010): rd_i = mem[rs1 + imm].
- ST (00011): mem[rs1 + imm] = rs2.
- BZ (00100): if rs1 == 0 then pc = pc + 1 + imm, else pc = pc + 1.
- HALT (11111): enter HALT.
- Any other opcode is illegal: set err, enter HALT.
- R0 reads as 0; writes to R0 are discarded.
- Arithmetic wraps modulo 2^DATA_W. No carry or overflow flags.
- FSM states: FETCH → DECODE → EXEC → {WB | MEM | FETCH | HALT}; MEM → WB (LD) or FETCH (ST); WB → FETCH. HALT is absorbing until reset.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold all three until mem_ready, then latch the instruction register and go to DECODE.
- DECODE: read rs1/rs2 into operand registers.
- EXEC: compute ALU result or address. BZ updates pc here; all non-branch instructions do pc+1 here.
- MEM: mem_req=1 with address, we and wdata held stable until mem_ready.
- WB: write the register file; retire pulses.
- retire also pulses on the ST MEM-complete cycle and on the BZ EXEC cycle. HALT itself does not retire.

## Timing
- Reset (RESET=0 at a rising edge): pc=RESET_PC, state FETCH, all registers 0, mem_req=0, retire=0, halted=0, err=0. The first fetch request appears in the first cycle after RESET is released.
- Reset asserted mid-instruction, including during a pending memory access: the access is abandoned and mem_req drops on the next edge. No register write occurs.
- Zero-wait memory cycle counts: AR, ARI = 4; LD = 5; ST = 4; BZ = 3; HALT = 3 until halted=1.
- Each cycle with mem_ready low adds exactly one cycle. Outputs are stable during stalls.
- mem_req is never asserted in DECODE, EXEC, WB or HALT.
- halted rises on the edge leaving EXEC; err rises on the same edge for illegal opcodes.
- Register write in WB is visible to the next instruction's DECODE. No forwarding is needed.

## Structure
- proc_pkg holds opcode constants, ALU func constants, the field bit positions and the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
- Sub-module proc_regfile (NREGS, DATA_W): two asynchronous read ports, one synchronous write port, R0 forced to 0, synchronous active-low clear.
- The ALU is an inline combinational case on func, using the package constants.

## Test plan
- Reset and ARI: RESET low for 2 cycles, then ARI R1=R0+5 followed by ARI R2=R0-3. Required: R1=5, R2=0xFFFFFFFD, retire pulses at cycles 4 and 8, pc=2.
- AR ops: R1=5, R2=0xFFFFFFFD. Then SUB R3=R1-R2 gives 8; SLT R4=R2<R1 gives 1; SRL R5=R2>>R1 gives 0x07FFFFFF.
- Memory with wait states: mem_ready held low 3 cycles on every access. ST R1→[R0+100], then LD R6=[R0+100]. Required: R6=5, mem_addr=100 stable throughout, LD takes 8 cycles.
- Branch: R0 test with BZ imm=-1 loops back to itself (pc unchanged) while retire pulses every 3 cycles. A BZ on R1=5 falls through to pc+1.
- Illegal and halt: opcode 01010 sets err=1 and halted=1 with no further mem_req. Write to R0 via ARI R0=R0+7 leaves R0 reading 0.
- Mid-operation reset: RESET low during a stalled LD MEM cycle. Required: mem_req=0 the next cycle, R6 unchanged (0 after clear), and the fetch restarts at RESET_PC.
